// File: rtl/unified_transform_scheduler_if.sv
// Signal bundle between the transform scheduler, its job source, the PWM/RNS
// requesters and the unified FFT/NTT unit.
interface unified_transform_scheduler_if;
    // Job handshake: tf_valid is raised with stable tf_* fields and held until
    // the cycle tf_valid && tf_ready, which is the single acceptance cycle.
    logic       tf_valid;
    logic       tf_ready;
    logic       tf_is_fft;
    logic       tf_is_dif;
    logic [3:0] tf_num_limbs;
    logic [2:0] tf_constants_sel;
    logic       tf_done;
    logic       pwm_req;
    logic       pwm_gnt;
    logic       rns_req;
    logic       rns_gnt;
    logic       ut_rst;
    logic       ut_is_fft;
    logic       ut_is_dif;
    logic [3:0] ut_current_k;
    logic [2:0] ut_constants_sel;
    logic       ut_rst_pwm;
    logic       ut_done;
    logic       err;
    logic [2:0] state_dbg;

    modport master (
        output tf_valid, tf_is_fft, tf_is_dif, tf_num_limbs, tf_constants_sel,
        output pwm_req, rns_req, ut_done,
        input  tf_ready, tf_done, pwm_gnt, rns_gnt,
        input  ut_rst, ut_is_fft, ut_is_dif, ut_current_k, ut_constants_sel,
        input  ut_rst_pwm, err, state_dbg
    );

    modport slave (
        input  tf_valid, tf_is_fft, tf_is_dif, tf_num_limbs, tf_constants_sel,
        input  pwm_req, rns_req, ut_done,
        output tf_ready, tf_done, pwm_gnt, rns_gnt,
        output ut_rst, ut_is_fft, ut_is_dif, ut_current_k, ut_constants_sel,
        output ut_rst_pwm, err, state_dbg
    );
endinterface

// File: rtl/unified_transform_scheduler.sv
// Sequences FFT/NTT jobs on the unified transformation unit and lends its idle
// butterflies/multiplier to the PWM and RNS requesters.
module unified_transform_scheduler #(
    parameter int MAX_K      = 8,
    parameter int RST_CYCLES = 4,
    parameter int TIMEOUT    = 65535
) (
    input logic clk,
    input logic rst,
    unified_transform_scheduler_if.slave bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int RC_W = $clog2(RST_CYCLES + 1);
    localparam logic [3:0]      MAX_K_L  = 4'(MAX_K);
    localparam logic [RC_W-1:0] RC_LAST  = RC_W'(RST_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PRE_RST = 3'd1,
        S_RUN     = 3'd2,
        S_NEXT    = 3'd3,
        S_ABORT   = 3'd4
    } state_t;

    typedef enum logic {
        PRIO_SHARED = 1'b0,
        PRIO_TF     = 1'b1
    } prio_t;

    state_t          state_q, state_d;
    prio_t           prio_q, prio_d;
    logic [RC_W-1:0] rc_q, rc_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [3:0]      limbs_q, limbs_d;
    logic [3:0]      limbs_req;
    logic            ut_rst_q, ut_rst_d;
    logic            ut_rst_pwm_q, ut_rst_pwm_d;
    logic            ut_is_fft_q, ut_is_fft_d;
    logic            ut_is_dif_q, ut_is_dif_d;
    logic [3:0]      ut_k_q, ut_k_d;
    logic [2:0]      ut_cs_q, ut_cs_d;
    logic            pwm_gnt_q, pwm_gnt_d;
    logic            rns_gnt_q, rns_gnt_d;
    logic            tf_done_q, tf_done_d;
    logic            err_q, err_d;
    logic            tf_ready_w;
    logic            accept;
    logic            grant_block;

    // Shared users win a tie unless the job has already been promised the unit.
    assign tf_ready_w = (state_q == S_IDLE) && !pwm_gnt_q && !rns_gnt_q &&
                        !(prio_q == PRIO_SHARED && (bus.pwm_req || bus.rns_req));
    assign accept      = bus.tf_valid && tf_ready_w;
    assign grant_block = bus.tf_valid && (prio_q == PRIO_TF);

    always_comb begin
        limbs_req = bus.tf_num_limbs;
        if (bus.tf_is_fft || bus.tf_num_limbs == 4'd0) begin
            limbs_req = 4'd1;
        end else if (bus.tf_num_limbs > MAX_K_L) begin
            limbs_req = MAX_K_L;
        end
    end

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        rc_d        = rc_q;
        wd_d        = wd_q;
        limbs_d     = limbs_q;
        ut_rst_d    = ut_rst_q;
        ut_is_fft_d = ut_is_fft_q;
        ut_is_dif_d = ut_is_dif_q;
        ut_k_d      = ut_k_q;
        ut_cs_d     = ut_cs_q;
        pwm_gnt_d   = 1'b0;
        rns_gnt_d   = 1'b0;
        tf_done_d   = 1'b0;
        err_d       = err_q;

        case (state_q)
            S_IDLE: begin
                ut_rst_d = 1'b1;
                if (accept) begin
                    ut_is_fft_d = bus.tf_is_fft;
                    ut_is_dif_d = bus.tf_is_dif;
                    ut_cs_d     = bus.tf_constants_sel;
                    limbs_d     = limbs_req;
                    ut_k_d      = 4'd0;
                    rc_d        = '0;
                    state_d     = S_PRE_RST;
                end else begin
                    // A held grant follows its request; release wins over re-request.
                    pwm_gnt_d = pwm_gnt_q ? bus.pwm_req : (bus.pwm_req && !grant_block);
                    rns_gnt_d = rns_gnt_q ? bus.rns_req : (bus.rns_req && !grant_block);
                    if ((pwm_gnt_q || rns_gnt_q) && !pwm_gnt_d && !rns_gnt_d && bus.tf_valid) begin
                        prio_d = PRIO_TF;
                    end
                end
            end
            S_PRE_RST: begin
                ut_rst_d = 1'b1;
                wd_d     = '0;
                if (rc_q == RC_LAST) begin
                    ut_rst_d = 1'b0;
                    state_d  = S_RUN;
                end else begin
                    rc_d = rc_q + RC_W'(1);
                end
            end
            S_RUN: begin
                ut_rst_d = 1'b0;
                if (bus.ut_done) begin
                    ut_rst_d = 1'b1;
                    state_d  = S_NEXT;
                end else if (wd_q == WD_LAST) begin
                    ut_rst_d = 1'b1;
                    state_d  = S_ABORT;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            S_NEXT: begin
                ut_rst_d = 1'b1;
                if (({1'b0, ut_k_q} + 5'd1) < {1'b0, limbs_q}) begin
                    ut_k_d  = ut_k_q + 4'd1;
                    rc_d    = '0;
                    state_d = S_PRE_RST;
                end else begin
                    tf_done_d   = 1'b1;
                    prio_d      = PRIO_SHARED;
                    ut_k_d      = 4'd0;
                    ut_is_fft_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_ABORT: begin
                ut_rst_d    = 1'b1;
                err_d       = 1'b1;
                tf_done_d   = 1'b1;
                prio_d      = PRIO_SHARED;
                ut_k_d      = 4'd0;
                ut_is_fft_d = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                ut_rst_d = 1'b1;
                state_d  = S_IDLE;
            end
        endcase

        ut_rst_pwm_d = ~pwm_gnt_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            prio_q       <= PRIO_SHARED;
            rc_q         <= '0;
            wd_q         <= '0;
            limbs_q      <= 4'd1;
            ut_rst_q     <= 1'b1;
            ut_rst_pwm_q <= 1'b1;
            ut_is_fft_q  <= 1'b0;
            ut_is_dif_q  <= 1'b0;
            ut_k_q       <= 4'd0;
            ut_cs_q      <= 3'd0;
            pwm_gnt_q    <= 1'b0;
            rns_gnt_q    <= 1'b0;
            tf_done_q    <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            rc_q         <= rc_d;
            wd_q         <= wd_d;
            limbs_q      <= limbs_d;
            ut_rst_q     <= ut_rst_d;
            ut_rst_pwm_q <= ut_rst_pwm_d;
            ut_is_fft_q  <= ut_is_fft_d;
            ut_is_dif_q  <= ut_is_dif_d;
            ut_k_q       <= ut_k_d;
            ut_cs_q      <= ut_cs_d;
            pwm_gnt_q    <= pwm_gnt_d;
            rns_gnt_q    <= rns_gnt_d;
            tf_done_q    <= tf_done_d;
            err_q        <= err_d;
        end
    end

    assign bus.tf_ready         = tf_ready_w;
    assign bus.tf_done          = tf_done_q;
    assign bus.pwm_gnt          = pwm_gnt_q;
    assign bus.rns_gnt          = rns_gnt_q;
    assign bus.ut_rst           = ut_rst_q;
    assign bus.ut_is_fft        = ut_is_fft_q;
    assign bus.ut_is_dif        = ut_is_dif_q;
    assign bus.ut_current_k     = ut_k_q;
    assign bus.ut_constants_sel = ut_cs_q;
    assign bus.ut_rst_pwm       = ut_rst_pwm_q;
    assign bus.err              = err_q;
    assign bus.state_dbg        = state_q;
endmodule

// File: tb/tb_unified_transform_scheduler.sv
// Self-checking bench for unified_transform_scheduler: table jobs, grant
// arbitration sequences, randomized jobs against a pass-count model, reset mid-job.
module tb_unified_transform_scheduler;
    localparam int MAXK = 8;
    localparam int RSTC = 4;
    localparam int TMO  = 50;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    bit   err_m;

    unified_transform_scheduler_if bus();

    unified_transform_scheduler #(
        .MAX_K(MAXK), .RST_CYCLES(RSTC), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench time limit");
    end

    typedef struct {
        bit         fft;
        bit         dif;
        logic [3:0] nl;
        logic [2:0] cs;
        int         dly;
        bit         hold;
        int         exp_passes;
        bit         exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
        end
    endtask

    // Number of unit passes a job should take, straight from the job rules.
    function automatic int model_passes(input bit fft, input int nl);
        if (fft) return 1;
        if (nl < 1) return 1;
        if (nl > MAXK) return MAXK;
        return nl;
    endfunction

    task automatic run_job(input int tag, input bit fft, input bit dif, input logic [3:0] nl,
                           input logic [2:0] cs, input int dly, input bit hold,
                           input int exp_passes, input bit exp_err);
        int w, hc, lc, stray;
        stray = 0;
        bus.tf_is_fft = fft;
        bus.tf_is_dif = dif;
        bus.tf_num_limbs = nl;
        bus.tf_constants_sel = cs;
        bus.tf_valid = 1'b1;
        w = 0;
        while (bus.tf_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk($sformatf("j%0d_accept", tag), 32'(w < 400), 1);
        @(negedge clk);
        bus.tf_valid = 1'b0;
        chk($sformatf("j%0d_mode", tag), {bus.ut_is_fft, bus.ut_is_dif, bus.ut_constants_sel},
            {fft, dif, cs});
        for (int p = 0; p < exp_passes; p++) begin
            hc = 0;
            while (bus.ut_rst === 1'b1 && hc < 40) begin
                if (bus.tf_done) stray++;
                bus.ut_done = 1'($urandom_range(0, 1));
                hc++;
                @(negedge clk);
            end
            bus.ut_done = 1'b0;
            chk($sformatf("j%0d_p%0d_rstlen", tag, p), hc, (p == 0) ? RSTC : RSTC + 1);
            chk($sformatf("j%0d_p%0d_k", tag, p), bus.ut_current_k, p);
            chk($sformatf("j%0d_p%0d_busy", tag, p), {bus.tf_ready, bus.pwm_gnt, bus.rns_gnt}, 0);
            lc = 0;
            while (bus.ut_rst === 1'b0 && lc < TMO + 10) begin
                if (bus.tf_done) stray++;
                lc++;
                if (!hold && lc == dly) bus.ut_done = 1'b1;
                @(negedge clk);
                bus.ut_done = 1'b0;
            end
            chk($sformatf("j%0d_p%0d_runlen", tag, p), lc, hold ? TMO : dly);
            if (hold) break;
        end
        chk($sformatf("j%0d_early_done", tag), stray + 32'(bus.tf_done), 0);
        @(negedge clk);
        chk($sformatf("j%0d_done", tag), bus.tf_done, 1);
        chk($sformatf("j%0d_end", tag), {bus.ut_rst, bus.ut_is_fft, bus.ut_current_k},
            {1'b1, 1'b0, 4'd0});
        chk($sformatf("j%0d_err", tag), bus.err, exp_err);
        @(negedge clk);
        chk($sformatf("j%0d_done_pulse", tag), bus.tf_done, 0);
    endtask

    bit         r_fft, r_dif, r_hold, pp, pr, np_, nr;
    logic [3:0] r_nl;
    logic [2:0] r_cs;
    int         r_dly, r_np, w;

    initial begin
        checks = 0;
        failures = 0;
        err_m = 1'b0;
        rst = 1'b1;
        bus.tf_valid = 1'b0;
        bus.tf_is_fft = 1'b0;
        bus.tf_is_dif = 1'b0;
        bus.tf_num_limbs = 4'd0;
        bus.tf_constants_sel = 3'd0;
        bus.pwm_req = 1'b1;
        bus.rns_req = 1'b0;
        bus.ut_done = 1'b0;

        vecs[0] = '{1'b1, 1'b1, 4'd0,  3'd5, 40, 1'b0, 1, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 4'd3,  3'd2, 7,  1'b0, 3, 1'b0};
        vecs[2] = '{1'b0, 1'b1, 4'd0,  3'd7, 12, 1'b0, 1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 4'd12, 3'd1, 3,  1'b0, 8, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 4'd9,  3'd4, TMO, 1'b0, 1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 4'd2,  3'd6, 0,  1'b1, 1, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 4'd8,  3'd3, 1,  1'b0, 8, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 4'd15, 3'd0, 5,  1'b0, 8, 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {bus.ut_rst, bus.ut_rst_pwm, bus.ut_is_fft, bus.ut_is_dif, bus.ut_current_k,
             bus.ut_constants_sel, bus.pwm_gnt, bus.rns_gnt, bus.tf_done, bus.err},
            {1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        bus.pwm_req = 1'b0;
        @(negedge clk);
        chk("reset_ready", {bus.tf_ready, bus.pwm_gnt}, {1'b1, 1'b0});

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].hold) err_m = 1'b1;
            run_job(i, vecs[i].fft, vecs[i].dif, vecs[i].nl, vecs[i].cs, vecs[i].dly,
                    vecs[i].hold, vecs[i].exp_passes, vecs[i].exp_err);
        end

        // Shared grants block a pending job until both requesters let go.
        bus.pwm_req = 1'b1;
        bus.rns_req = 1'b1;
        @(negedge clk);
        chk("gnt_both", {bus.pwm_gnt, bus.rns_gnt, bus.ut_rst_pwm, bus.ut_rst}, 4'b1101);
        fork
            run_job(20, 1'b1, 1'b0, 4'd5, 3'd2, 20, 1'b0, 1, err_m);
            begin
                int ww;
                repeat (3) begin
                    @(negedge clk);
                    chk("gnt_hold_ready", {bus.tf_ready, bus.pwm_gnt, bus.rns_gnt}, 3'b011);
                end
                bus.pwm_req = 1'b0;
                @(negedge clk);
                chk("gnt_pwm_rel", {bus.pwm_gnt, bus.rns_gnt, bus.ut_rst_pwm, bus.tf_ready},
                    4'b0110);
                bus.rns_req = 1'b0;
                @(negedge clk);
                chk("gnt_rns_rel", {bus.rns_gnt, bus.tf_ready}, 2'b01);
                bus.pwm_req = 1'b1;
                ww = 0;
                while (bus.tf_done !== 1'b1 && ww < 3000) begin
                    @(negedge clk);
                    ww++;
                end
                chk("gnt_wait_done", 32'(ww < 3000), 1);
                @(negedge clk);
                chk("gnt_after_done", {bus.pwm_gnt, bus.ut_rst_pwm}, 2'b10);
                bus.pwm_req = 1'b0;
                @(negedge clk);
                chk("gnt_final_rel", bus.pwm_gnt, 0);
            end
        join

        // Random request levels with no job pending: grant tracks the request one cycle late.
        pp = 1'b0;
        pr = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            chk($sformatf("rgnt%0d", i), {bus.pwm_gnt, bus.rns_gnt, bus.ut_rst_pwm},
                {pp, pr, ~pp});
            np_ = 1'($urandom_range(0, 1));
            nr = 1'($urandom_range(0, 1));
            bus.pwm_req = np_;
            bus.rns_req = nr;
            #1;
            chk($sformatf("rready%0d", i), bus.tf_ready, !(pp || pr || np_ || nr));
            pp = np_;
            pr = nr;
        end
        bus.pwm_req = 1'b0;
        bus.rns_req = 1'b0;
        repeat (2) @(negedge clk);

        // ut_done outside RUN must do nothing.
        bus.ut_done = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stray_done_idle", {bus.tf_done, bus.ut_rst, bus.tf_ready}, 3'b011);
        end
        bus.ut_done = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            r_fft = 1'($urandom_range(0, 1));
            r_dif = 1'($urandom_range(0, 1));
            r_nl = 4'($urandom_range(0, 15));
            r_cs = 3'($urandom_range(0, 7));
            r_dly = $urandom_range(1, TMO);
            r_hold = ($urandom_range(0, 9) == 0);
            r_np = model_passes(r_fft, int'(r_nl));
            if (r_hold) err_m = 1'b1;
            run_job(100 + i, r_fft, r_dif, r_nl, r_cs, r_dly, r_hold, r_np, err_m);
        end

        // Reset in the middle of the second limb of a 3-limb NTT.
        bus.tf_is_fft = 1'b0;
        bus.tf_is_dif = 1'b1;
        bus.tf_num_limbs = 4'd3;
        bus.tf_constants_sel = 3'd1;
        bus.tf_valid = 1'b1;
        w = 0;
        while (bus.tf_ready !== 1'b1 && w < 400) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        bus.tf_valid = 1'b0;
        w = 0;
        while (bus.ut_rst !== 1'b0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        bus.ut_done = 1'b1;
        @(negedge clk);
        bus.ut_done = 1'b0;
        w = 0;
        while (bus.ut_rst !== 1'b0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("rstrun_k1", {bus.ut_rst, bus.ut_current_k}, {1'b0, 4'd1});
        bus.pwm_req = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstrun_out",
            {bus.ut_rst, bus.ut_current_k, bus.tf_done, bus.err, bus.pwm_gnt, bus.rns_gnt,
             bus.ut_rst_pwm},
            {1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        rst = 1'b0;
        bus.pwm_req = 1'b0;
        err_m = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rstrun_no_done", {bus.tf_done, bus.err, bus.ut_rst}, 3'b001);
        end
        run_job(200, 1'b0, 1'b0, 4'd2, 3'd3, 9, 1'b0, 2, err_m);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
